// File: rtl/addsub_sat_pipe.sv
// Lane-parallel LLR add/subtract (L-E or L+E) with symmetric saturation,
// a configurable-depth valid/ready pipeline and a saturating clamp counter.
module addsub_sat_pipe #(
    parameter int W      = 6,
    parameter int Wc     = 32,
    parameter int STAGES = 2,
    parameter int CW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mode,
    input  logic [W*Wc-1:0] L,
    input  logic [W*Wc-1:0] E,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W*Wc-1:0] res,
    output logic [Wc-1:0]   sat_flag,
    output logic [CW-1:0]   sat_cnt
);

    localparam int PW = $clog2(Wc + 1);
    localparam int SW = ((CW > PW) ? CW : PW) + 1;
    localparam logic signed [W:0] POS = (W+1)'((1 << (W-1)) - 1);
    localparam logic signed [W:0] NEG = -POS;

    // Returns {clamped, value}; the most negative code is never produced.
    function automatic logic [W:0] sat_sym(input logic signed [W:0] x);
        if (x > POS)
            return {1'b1, POS[W-1:0]};
        else if (x < NEG)
            return {1'b1, NEG[W-1:0]};
        else
            return {1'b0, x[W-1:0]};
    endfunction

    function automatic logic [PW-1:0] popcount(input logic [Wc-1:0] f);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < Wc; i++)
            n = n + PW'(f[i]);
        return n;
    endfunction

    function automatic logic [CW-1:0] sat_acc(input logic [CW-1:0] acc,
                                              input logic [PW-1:0] inc);
        logic [SW-1:0] s;
        s = SW'(acc) + SW'(inc);
        if (s > SW'({CW{1'b1}}))
            return '1;
        else
            return s[CW-1:0];
    endfunction

    logic [W*Wc-1:0] res_c;
    logic [Wc-1:0]   flag_c;

    always_comb begin
        res_c  = '0;
        flag_c = '0;
        for (int k = 0; k < Wc; k++) begin
            logic signed [W:0] a;
            logic signed [W:0] b;
            logic signed [W:0] s;
            logic [W:0]        r;
            a = $signed({L[W*k+W-1], L[W*k +: W]});
            b = $signed({E[W*k+W-1], E[W*k +: W]});
            s = mode ? (a + b) : (a - b);
            r = sat_sym(s);
            res_c[W*k +: W] = r[W-1:0];
            flag_c[k]       = r[W];
        end
    end

    logic            vld_p  [STAGES];
    logic [W*Wc-1:0] res_p  [STAGES];
    logic [Wc-1:0]   flag_p [STAGES];
    logic            adv;

    assign out_valid = vld_p[STAGES-1];
    assign res       = res_p[STAGES-1];
    assign sat_flag  = flag_p[STAGES-1];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    // Stage boundary: all stages move together; bubbles are kept in place.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_p[s]  <= 1'b0;
                res_p[s]  <= '0;
                flag_p[s] <= '0;
            end
            sat_cnt <= '0;
        end else if (clr) begin
            for (int s = 0; s < STAGES; s++)
                vld_p[s] <= 1'b0;
            sat_cnt <= '0;
        end else begin
            if (out_valid && out_ready)
                sat_cnt <= sat_acc(sat_cnt, popcount(sat_flag));
            if (adv) begin
                vld_p[0]  <= in_valid & in_ready;
                res_p[0]  <= res_c;
                flag_p[0] <= flag_c;
                for (int s = 1; s < STAGES; s++) begin
                    vld_p[s]  <= vld_p[s-1];
                    res_p[s]  <= res_p[s-1];
                    flag_p[s] <= flag_p[s-1];
                end
            end
        end
    end

endmodule
